// File: rtl/ram_dma_pkg.sv
// ---------------------------------------------------------------------------
// ram_dma_pkg
// Shared definitions for the ram_dma block-transfer engine.
//   state_t   : engine states (IDLE / READ / WRITE / DONE)
//   MODE_COPY : mode input value selecting a memory-to-memory copy
//   MODE_FILL : mode input value selecting a constant fill
// ---------------------------------------------------------------------------
package ram_dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_agen.sv
// ---------------------------------------------------------------------------
// ram_dma_agen
// Address generator for ram_dma: source pointer, destination pointer and
// remaining-word counter. Loaded at transfer start, stepped once per write.
// Pointers wrap naturally modulo 2^addr_width.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture src/dst/count as the new transfer parameters
//   step        : advance both pointers and decrement the remaining count
//   src, dst    : base addresses presented at load
//   count       : number of words presented at load
//   src_ptr     : current read address
//   dst_ptr     : current write address
//   last        : remaining == 1 (the word being written is the final one)
// ---------------------------------------------------------------------------
module ram_dma_agen
   import ram_dma_pkg::*;
#(
   parameter int addr_width = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic [addr_width-1:0] src,
   input  logic [addr_width-1:0] dst,
   input  logic [addr_width-1:0] count,
   output logic [addr_width-1:0] src_ptr,
   output logic [addr_width-1:0] dst_ptr,
   output logic                  last
);

   localparam logic [addr_width-1:0] ptr_one = addr_width'(1);

   logic [addr_width-1:0] remaining;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
      end else if (load) begin
         src_ptr   <= src;
         dst_ptr   <= dst;
         remaining <= count;
      end else if (step) begin
         src_ptr   <= src_ptr + ptr_one;
         dst_ptr   <= dst_ptr + ptr_one;
         remaining <= remaining - ptr_one;
      end
   end

   assign last = (remaining == ptr_one);

endmodule

// File: rtl/ram_dma.sv
// ---------------------------------------------------------------------------
// ram_dma
// Single-channel block-transfer engine driving one RAM port. Performs forward
// memory-to-memory copies (2 cycles/word) and, when the RAM_DMA_FILL_EN macro
// is defined, constant fills (1 cycle/word). Without RAM_DMA_FILL_EN the mode
// and fill_val inputs are ignored and every transfer is a copy.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a transfer (sampled only in IDLE)
//   mode             : 0 = copy, 1 = fill (latched at start)
//   src, dst, count  : source base, destination base, word count (latched)
//   fill_val         : fill pattern (latched at start)
//   abort            : finish the current word, then stop
//   busy             : transfer in progress (READ/WRITE states)
//   done             : one-cycle completion pulse
//   ram_cs/oe/wr     : RAM control lines
//   ram_addr, ram_din: RAM address and write data
//   ram_q            : RAM read data (valid at the posedge ending a READ)
// ---------------------------------------------------------------------------
module ram_dma
   import ram_dma_pkg::*;
#(
   parameter int addr_width = 16,
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [addr_width-1:0] src,
   input  logic [addr_width-1:0] dst,
   input  logic [addr_width-1:0] count,
   input  logic [data_width-1:0] fill_val,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_cs,
   output logic                  ram_oe,
   output logic                  ram_wr,
   output logic [addr_width-1:0] ram_addr,
   output logic [data_width-1:0] ram_din,
   input  logic [data_width-1:0] ram_q
);

   state_t                state;
   state_t                next_state;
   logic                  load;
   logic                  step;
   logic                  last;
   logic                  start_fill;
   logic                  fill_sel;
   logic                  abort_pending;
   logic [addr_width-1:0] src_ptr;
   logic [addr_width-1:0] dst_ptr;
   logic [data_width-1:0] data_reg;
   logic [data_width-1:0] wdata;

   assign load = (state == IDLE) && start;
   assign step = (state == WRITE);

   ram_dma_agen #(
      .addr_width (addr_width)
   ) u_agen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .src     (src),
      .dst     (dst),
      .count   (count),
      .src_ptr (src_ptr),
      .dst_ptr (dst_ptr),
      .last    (last)
   );

`ifdef RAM_DMA_FILL_EN
   logic                  mode_reg;
   logic [data_width-1:0] fill_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_reg <= MODE_COPY;
         fill_reg <= '0;
      end else if (load) begin
         mode_reg <= mode;
         fill_reg <= fill_val;
      end
   end

   assign start_fill = (mode == MODE_FILL);
   assign fill_sel   = (mode_reg == MODE_FILL);
   assign wdata      = fill_sel ? fill_reg : data_reg;
`else
   // Fill path is compiled out; fold the dead inputs into one sink.
   logic unused_cfg;
   assign unused_cfg = ^{mode, fill_val};
   assign start_fill = 1'b0;
   assign fill_sel   = 1'b0;
   assign wdata      = data_reg;
`endif

   // Word read in READ is valid at the posedge that ends the READ cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg <= '0;
      end else if (state == READ) begin
         data_reg <= ram_q;
      end
   end

   // An abort seen during READ must still let the paired WRITE complete,
   // so it is remembered until the WRITE decides the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abort_pending <= 1'b0;
      end else if (load || state == DONE) begin
         abort_pending <= 1'b0;
      end else if (state == READ && abort) begin
         abort_pending <= 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  next_state = DONE;
               end else if (start_fill) begin
                  next_state = WRITE;
               end else begin
                  next_state = READ;
               end
            end
         end
         READ: begin
            next_state = WRITE;
         end
         WRITE: begin
            if (last || abort || abort_pending) begin
               next_state = DONE;
            end else if (fill_sel) begin
               next_state = WRITE;
            end else begin
               next_state = READ;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output decode: purely from the state register, so an asynchronous reset
   // drops the RAM controls immediately.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      ram_cs   = 1'b0;
      ram_oe   = 1'b0;
      ram_wr   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      unique case (state)
         READ: begin
            busy     = 1'b1;
            ram_cs   = 1'b1;
            ram_oe   = 1'b1;
            ram_addr = src_ptr;
         end
         WRITE: begin
            busy     = 1'b1;
            ram_cs   = 1'b1;
            ram_wr   = 1'b1;
            ram_addr = dst_ptr;
            ram_din  = wdata;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ram_dma.sv
// ---------------------------------------------------------------------------
// tb_ram_dma
// Self-checking bench for ram_dma. Contains a behavioural RAM (Q updated on
// negedge, writes on negedge) and a word-level reference memory that applies
// each transfer as a simple forward loop. Works with or without
// RAM_DMA_FILL_EN defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_dma;

   localparam int LIMIT = 200;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [15:0] src;
   logic [15:0] dst;
   logic [15:0] count;
   logic [7:0]  fill_val;
   logic        abort;
   logic        busy;
   logic        done;
   logic        ram_cs;
   logic        ram_oe;
   logic        ram_wr;
   logic [15:0] ram_addr;
   logic [7:0]  ram_din;
   logic [7:0]  ram_q;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  exp_mem [0:65535];
   logic [15:0] rd_log  [$];
   logic [15:0] wr_log  [$];
   int          first_diff;

   ram_dma #(.addr_width(16), .data_width(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .src      (src),
      .dst      (dst),
      .count    (count),
      .fill_val (fill_val),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .ram_cs   (ram_cs),
      .ram_oe   (ram_oe),
      .ram_wr   (ram_wr),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_q    (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM plus bus access log.
   always @(negedge clk) begin
      if (ram_cs && ram_wr) begin
         mem[ram_addr] = ram_din;
         wr_log.push_back(ram_addr);
      end
      if (ram_cs && ram_oe) begin
         ram_q = mem[ram_addr];
         rd_log.push_back(ram_addr);
      end
   end

   // ---------------- reference model ----------------
   function automatic void model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
      logic [15:0] sa, da;
      sa = s;
      da = d;
      for (int i = 0; i < n; i++) begin
         exp_mem[da] = exp_mem[sa];
         sa = sa + 16'd1;
         da = da + 16'd1;
      end
   endfunction

   function automatic void model_fill(input logic [15:0] d, input int n, input logic [7:0] v);
      logic [15:0] da;
      da = d;
      for (int i = 0; i < n; i++) begin
         exp_mem[da] = v;
         da = da + 16'd1;
      end
   endfunction

   function automatic int count_mem_diffs();
      int n;
      n = 0;
      first_diff = -1;
      for (int i = 0; i < 65536; i++) begin
         if (mem[i] !== exp_mem[i]) begin
            if (n == 0) first_diff = i;
            n++;
         end
      end
      return n;
   endfunction

   function automatic bit fill_effective(input logic m);
`ifdef RAM_DMA_FILL_EN
      return m;
`else
      return (m & 1'b0);
`endif
   endfunction

   function automatic int expected_cycles(input logic m, input int n);
      if (n == 0) return 1;
      return fill_effective(m) ? n + 1 : 2 * n + 1;
   endfunction

   // ---------------- transfer driver ----------------
   // Launches one transfer and counts negedges from the start edge to done.
   // abort_k > 0 pulses abort for the cycle observed at negedge k.
   // with_abort drives abort together with start; inject drives a second start mid-run.
   task automatic do_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] c, input logic [7:0] f, input int abort_k,
                          input bit with_abort, input bit inject,
                          output int cycles, output bit busy_ok, output bit tail_ok);
      rd_log.delete();
      wr_log.delete();
      @(negedge clk);
      mode = m; src = s; dst = d; count = c; fill_val = f;
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      cycles = -1;
      busy_ok = 1'b1;
      for (int k = 1; k <= LIMIT; k++) begin
         if (k > 1) @(negedge clk);
         abort = (k == abort_k);
         if (inject && k == 2) begin
            start = 1'b1; mode = 1'b0; src = 16'h4000; dst = 16'h4100; count = 16'd5;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            cycles = k;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      tail_ok = !done && !busy && !ram_cs;
      repeat (3) begin
         @(negedge clk);
         if (busy || done || ram_cs) tail_ok = 1'b0;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_checks++;
      if ({busy, done, ram_cs, ram_oe, ram_wr, ram_addr, ram_din} !== 29'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b cs=%b oe=%b wr=%b addr=%h din=%h, want all 0",
                  busy, done, ram_cs, ram_oe, ram_wr, ram_addr, ram_din);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, ram_cs} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_idle: got busy=%b done=%b cs=%b, want 000", busy, done, ram_cs);
      end
   endtask

   task automatic test_copy();
      int cyc; bit bok, tok;
      logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         mem[16'h0100 + i] = pat[i];
         exp_mem[16'h0100 + i] = pat[i];
      end
      model_copy(16'h0100, 16'h0200, 4);
      do_xfer(1'b0, 16'h0100, 16'h0200, 16'd4, 8'h00, 0, 1'b0, 1'b0, cyc, bok, tok);
      n_checks++;
      if (cyc !== 9) begin
         n_errors++;
         $display("FAIL copy_latency: got %0d cycles, want 9", cyc);
      end
      n_checks++;
      if (!bok || !tok) begin
         n_errors++;
         $display("FAIL copy_busy_done: busy_held=%b single_done_pulse=%b, want 1 1", bok, tok);
      end
      n_checks++;
      if (count_mem_diffs() !== 0) begin
         n_errors++;
         $display("FAIL copy_data: mem[%h]=%h, want %h", first_diff, mem[first_diff], exp_mem[first_diff]);
      end
   endtask

   task automatic test_fill();
      int cyc; bit bok, tok;
      logic [15:0] s;
      s = 16'h0100;
      if (fill_effective(1'b1)) model_fill(16'h0300, 3, 8'hA5);
      else                      model_copy(s, 16'h0300, 3);
      do_xfer(1'b1, s, 16'h0300, 16'd3, 8'hA5, 0, 1'b0, 1'b0, cyc, bok, tok);
      n_checks++;
      if (cyc !== expected_cycles(1'b1, 3)) begin
         n_errors++;
         $display("FAIL fill_latency: got %0d cycles, want %0d", cyc, expected_cycles(1'b1, 3));
      end
      n_checks++;
      if (count_mem_diffs() !== 0) begin
         n_errors++;
         $display("FAIL fill_data: mem[%h]=%h, want %h", first_diff, mem[first_diff], exp_mem[first_diff]);
      end
      n_checks++;
      if (!bok || !tok) begin
         n_errors++;
         $display("FAIL fill_busy_done: busy_held=%b single_done_pulse=%b, want 1 1", bok, tok);
      end
   endtask

   task automatic test_wrap();
      int cyc; bit bok, tok;
      logic [15:0] exp_rd [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      logic [15:0] exp_wr [4] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
      bit order_ok;
      model_copy(16'hFFFE, 16'h1000, 4);
      do_xfer(1'b0, 16'hFFFE, 16'h1000, 16'd4, 8'h00, 0, 1'b0, 1'b0, cyc, bok, tok);
      order_ok = (rd_log.size() == 4) && (wr_log.size() == 4);
      if (order_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (rd_log[i] !== exp_rd[i] || wr_log[i] !== exp_wr[i]) order_ok = 1'b0;
         end
      end
      n_checks++;
      if (!order_ok) begin
         n_errors++;
         $display("FAIL wrap_addresses: reads=%p writes=%p, want reads=%p writes=%p",
                  rd_log, wr_log, exp_rd, exp_wr);
      end
      n_checks++;
      if (count_mem_diffs() !== 0) begin
         n_errors++;
         $display("FAIL wrap_data: mem[%h]=%h, want %h", first_diff, mem[first_diff], exp_mem[first_diff]);
      end
   endtask

   task automatic test_count_zero();
      int cyc; bit bok, tok;
      do_xfer(1'b0, 16'h0500, 16'h0600, 16'd0, 8'h00, 0, 1'b0, 1'b0, cyc, bok, tok);
      n_checks++;
      if (cyc !== 1) begin
         n_errors++;
         $display("FAIL zero_latency: got %0d cycles, want 1", cyc);
      end
      n_checks++;
      if (rd_log.size() !== 0 || wr_log.size() !== 0 || !tok) begin
         n_errors++;
         $display("FAIL zero_no_access: reads=%0d writes=%0d tail_ok=%b, want 0 0 1",
                  rd_log.size(), wr_log.size(), tok);
      end
   endtask

   task automatic test_abort();
      int cyc; bit bok, tok;
      // Copy negedges: k=1 READ0, 2 WRITE0, 3 READ1, 4 WRITE1, 5 READ2.
      model_copy(16'h0700, 16'h0800, 3);
      do_xfer(1'b0, 16'h0700, 16'h0800, 16'd10, 8'h00, 5, 1'b0, 1'b1, cyc, bok, tok);
      n_checks++;
      if (cyc !== 7 || wr_log.size() !== 3 || rd_log.size() !== 3) begin
         n_errors++;
         $display("FAIL abort_in_read: cycles=%0d writes=%0d reads=%0d, want 7 3 3",
                  cyc, wr_log.size(), rd_log.size());
      end
      n_checks++;
      if (count_mem_diffs() !== 0 || !tok) begin
         n_errors++;
         $display("FAIL abort_data: diff_at=%0d tail_ok=%b, want -1 1", first_diff, tok);
      end
      // Abort during the 2nd WRITE stops right after that write.
      model_copy(16'h0900, 16'h0A00, 2);
      do_xfer(1'b0, 16'h0900, 16'h0A00, 16'd6, 8'h00, 4, 1'b0, 1'b0, cyc, bok, tok);
      n_checks++;
      if (cyc !== 5 || wr_log.size() !== 2 || count_mem_diffs() !== 0) begin
         n_errors++;
         $display("FAIL abort_in_write: cycles=%0d writes=%0d, want 5 2", cyc, wr_log.size());
      end
      // Start and abort together in IDLE: start wins, full transfer runs.
      model_copy(16'h0B00, 16'h0C00, 3);
      do_xfer(1'b0, 16'h0B00, 16'h0C00, 16'd3, 8'h00, 0, 1'b1, 1'b0, cyc, bok, tok);
      n_checks++;
      if (cyc !== 7 || wr_log.size() !== 3 || count_mem_diffs() !== 0) begin
         n_errors++;
         $display("FAIL start_with_abort: cycles=%0d writes=%0d, want 7 3", cyc, wr_log.size());
      end
   endtask

   task automatic test_reset_mid();
      int cyc; bit bok, tok;
      bit quiet;
      rd_log.delete();
      wr_log.delete();
      @(negedge clk);
      mode = 1'b0; src = 16'h2000; dst = 16'h2100; count = 16'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      // Reset lands in READ of word 2: words 0 and 1 are already written.
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, ram_cs, ram_oe, ram_wr, ram_addr, ram_din} !== 29'd0) begin
         n_errors++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b cs=%b oe=%b wr=%b addr=%h, want all 0",
                  busy, done, ram_cs, ram_oe, ram_wr, ram_addr);
      end
      model_copy(16'h2000, 16'h2100, 2);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (busy || done || ram_cs) quiet = 1'b0;
      end
      n_checks++;
      if (!quiet || count_mem_diffs() !== 0) begin
         n_errors++;
         $display("FAIL reset_mid_idle: quiet=%b diff_at=%0d, want 1 -1", quiet, first_diff);
      end
      model_copy(16'h2200, 16'h2300, 3);
      do_xfer(1'b0, 16'h2200, 16'h2300, 16'd3, 8'h00, 0, 1'b0, 1'b0, cyc, bok, tok);
      n_checks++;
      if (cyc !== 7 || !bok || !tok || count_mem_diffs() !== 0) begin
         n_errors++;
         $display("FAIL reset_mid_restart: cycles=%0d busy_ok=%b tail_ok=%b, want 7 1 1", cyc, bok, tok);
      end
   endtask

   task automatic test_random();
      int cyc; bit bok, tok;
      logic        m;
      logic [15:0] s, d;
      int          n;
      logic [7:0]  f;
      for (int t = 0; t < 12; t++) begin
         m = 1'($urandom_range(0, 1));
         s = 16'($urandom);
         d = 16'($urandom);
         n = int'($urandom_range(1, 8));
         f = 8'($urandom);
         if (t < 3) d = s + 16'($urandom_range(1, 3));   // forward overlap
         if (fill_effective(m)) model_fill(d, n, f);
         else                   model_copy(s, d, n);
         do_xfer(m, s, d, 16'(n), f, 0, 1'b0, 1'b0, cyc, bok, tok);
         n_checks++;
         if (cyc !== expected_cycles(m, n) || !bok || !tok || count_mem_diffs() !== 0) begin
            n_errors++;
            $display("FAIL random_%0d: mode=%b src=%h dst=%h n=%0d cycles=%0d want %0d busy_ok=%b tail_ok=%b diff_at=%0d",
                     t, m, s, d, n, cyc, expected_cycles(m, n), bok, tok, first_diff);
         end
      end
   endtask

   initial begin
      logic [7:0] v;
      start = 1'b0; mode = 1'b0; src = '0; dst = '0; count = '0;
      fill_val = '0; abort = 1'b0; ram_q = '0; rst_n = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         v = 8'($urandom);
         mem[i] = v;
         exp_mem[i] = v;
      end
      test_reset();
      test_copy();
      test_fill();
      test_wrap();
      test_count_zero();
      test_abort();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ram_dma.md
# ram_dma

Single-channel block-transfer engine that acts as the initiator on a `ram` instance's port, driving its chip-select, output-enable, write and address lines and sampling `Q`. It performs forward memory-to-memory copies, and optionally constant fills, within one RAM, so that firmware and test benches can move or clear blocks without a CPU bus. It sits between the system control logic (start/parameter handshake) and one RAM port.

## Interface
- `addr_width`, 16: RAM address width; also the width of the count.
- `data_width`, 8: RAM data width.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin transfer; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched at start.
- `src`  in  addr_width  copy source base; latched at start.
- `dst`  in  addr_width  destination base; latched at start.
- `count`  in  addr_width  number of words; latched at start; 0 is legal.
- `fill_val`  in  data_width  fill pattern; latched at start.
- `abort`  in  1  stop after the current word.
- `busy`  out  1  high from the cycle after an accepted start until DONE.
- `done`  out  1  one-cycle pulse on completion or abort.
- `ram_cs`, `ram_oe`, `ram_wr`  out  1 each  RAM control lines.
- `ram_addr`  out  addr_width  RAM address.
- `ram_din`  out  data_width  RAM write data.
- `ram_q`  in  data_width  RAM `Q`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 latches the parameters. Copy with count≠0 → READ. Fill with count≠0 → WRITE. count==0 → DONE with no RAM access.
- READ: `ram_cs`=1, `ram_oe`=1, `ram_wr`=0, `ram_addr`=src_ptr. Captures `ram_q` on the next posedge, then → WRITE.
- WRITE: `ram_cs`=1, `ram_wr`=1, `ram_oe`=0, `ram_addr`=dst_ptr.
  - `ram_din` is the captured word (copy) or fill_val (fill).
  - At the end of the cycle: increment both pointers and decrement remaining.
  - remaining==1 or abort seen → DONE; otherwise → READ (copy) or WRITE (fill).
- DONE: `done`=1 for one cycle, `busy`=0, → IDLE.
- Pointers wrap modulo 2^addr_width; for example, 0xFFFF+1 = 0x0000 at 16 bits.
- Copies are forward only. With overlap where dst>src, data already overwritten is what gets copied; this is by design.
- `abort` is sampled in READ and WRITE:
  - In READ, the pending WRITE still completes, then → DONE.
  - In WRITE, the engine → DONE after this write.
  - No write is ever left half-done.
- `start` while not IDLE is ignored. `start` and `abort` together in IDLE: start is accepted and the abort is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0. Reset asserted mid-transfer drops `ram_cs`/`ram_wr` immediately (asynchronously); no completion pulse follows.
- The RAM updates `Q` on negedge. Data for a READ cycle is therefore valid at the following posedge, where it is captured. Read latency is 1 cycle.
- Copy rate: 2 cycles per word. Fill rate: 1 cycle per word.
- Start to first RAM access: 1 cycle. Final write to `done`: 1 cycle.
- Total cycles from the start edge to the `done` pulse: 2N+1 (copy) or N+1 (fill); count=0 gives 1.
- `ram_cs` is low in IDLE and DONE. `ram_wr` is high only in WRITE.

## Configuration
- `RAM_DMA_FILL_EN` defined: fill mode as described above.
- `RAM_DMA_FILL_EN` undefined:
  - `mode` and `fill_val` are ignored and every transfer is a copy.
  - `fill_val` storage and the fill path are removed.

## Structure
- Package `ram_dma_pkg`: state enum (IDLE/READ/WRITE/DONE) and mode constants MODE_COPY=0, MODE_FILL=1.
- Sub-module `ram_dma_agen`: holds src_ptr, dst_ptr and remaining, with load/step inputs and a `last` output (remaining==1). The top level holds the FSM, data capture and RAM drive.

## Test plan
- Copy: preload 0x0100..0x0103 = 11,22,33,44; start copy src=0x0100, dst=0x0200, count=4 → 0x0200..0x0203 = 11,22,33,44; `done` pulses 9 cycles after start; `busy` is high throughout.
- Fill (with `RAM_DMA_FILL_EN`): dst=0x0300, count=3, fill_val=0xA5 → 0x0300..0x0302 = A5, 0x0303 untouched, `done` after 4 cycles. Without the macro: same stimulus with mode=1 performs a copy from src.
- Wrap: copy src=0xFFFE, dst=0x1000, count=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order; written to 0x1000..0x1003.
- count=0: start → `done` on the next cycle; `ram_cs` never asserted.
- Abort: copy count=10, abort asserted during the 3rd READ → exactly 3 words written, then `done`; a start during the transfer is ignored.
- Reset: `rst_n` low mid-copy → all outputs 0 immediately; after release the engine sits in IDLE, no `done`, and a new start works normally.
